// File: rtl/tap_input_encoder.sv
// Hole-switch front end: synchronise, debounce and rising-edge detect each input,
// then queue accepted presses and emit them as single-cycle one-hot taps, lowest hole first.
module tap_input_encoder #(
    parameter int unsigned N_HOLES         = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pause,
    input  logic [N_HOLES-1:0] sw,
    output logic [N_HOLES-1:0] tap,
    output logic               tap_valid,
    output logic [2:0]         tap_idx,
    output logic [N_HOLES-1:0] pending
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_HOLES-1:0] r_s1;
    logic [N_HOLES-1:0] r_s2;
    logic [N_HOLES-1:0] r_db;
    logic [N_HOLES-1:0] r_db_prev;
    logic [N_HOLES-1:0] r_pending;
    logic [N_HOLES-1:0] r_tap;
    logic               r_tap_valid;
    logic [2:0]         r_tap_idx;
    logic [CNT_W-1:0]   r_cnt [N_HOLES];

    logic [N_HOLES-1:0] w_db_d;
    logic [CNT_W-1:0]   w_cnt_d [N_HOLES];
    logic [N_HOLES-1:0] w_rise;
    logic [N_HOLES-1:0] w_grant;
    logic [N_HOLES-1:0] w_pending_d;
    logic [2:0]         w_idx;

    // db only follows s2 once it has disagreed for DEBOUNCE_CYCLES consecutive cycles
    always_comb begin
        for (int i = 0; i < int'(N_HOLES); i++) begin
            w_db_d[i]  = r_db[i];
            w_cnt_d[i] = '0;
            if (r_s2[i] != r_db[i]) begin
                if (r_cnt[i] == CntMax) begin
                    w_db_d[i] = r_s2[i];
                end else begin
                    w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_rise = r_db & ~r_db_prev;

    // Isolate the lowest set bit; pause blocks the grant outright
    assign w_grant = pause ? '0 : (r_pending & (~r_pending + N_HOLES'(1)));

    always_comb begin
        if (pause) begin
            w_pending_d = '0;
        end else begin
            w_pending_d = (r_pending & ~w_grant) | w_rise;
        end
    end

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < int'(N_HOLES); i++) begin
            if (w_grant[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_db        <= '0;
            r_db_prev   <= '0;
            r_pending   <= '0;
            r_tap       <= '0;
            r_tap_valid <= 1'b0;
            r_tap_idx   <= '0;
            for (int i = 0; i < int'(N_HOLES); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1        <= sw;
            r_s2        <= r_s1;
            r_db        <= w_db_d;
            r_db_prev   <= r_db;
            r_pending   <= w_pending_d;
            r_tap       <= w_grant;
            r_tap_valid <= |w_grant;
            r_tap_idx   <= w_idx;
            for (int i = 0; i < int'(N_HOLES); i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

    assign tap       = r_tap;
    assign tap_valid = r_tap_valid;
    assign tap_idx   = r_tap_idx;
    assign pending   = r_pending;

endmodule

// File: tb/tb_tap_input_encoder.sv
// Self-checking bench for tap_input_encoder with a short debounce window.
module tb_tap_input_encoder;

    localparam int unsigned Deb = 4;
    localparam int          Lat = Deb + 4;

    logic       clk;
    logic       rst_n;
    logic       pause;
    logic [7:0] sw;
    logic [7:0] tap;
    logic       tap_valid;
    logic [2:0] tap_idx;
    logic [7:0] pending;

    int n_checks;
    int n_fail;

    // Each entry: {tap[7:0], idx[2:0]}
    logic [10:0] exp_q [$];

    tap_input_encoder #(
        .N_HOLES        (8),
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pause    (pause),
        .sw       (sw),
        .tap      (tap),
        .tap_valid(tap_valid),
        .tap_idx  (tap_idx),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] t);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) if (t[i]) idx = 3'(i);
        return {t, idx};
    endfunction

    // Scoreboard monitor: every observed tap must match the head of the expected queue
    always @(negedge clk) begin
        logic [10:0] e;
        if (rst_n) begin
            if (tap !== 8'h00 || tap_valid !== 1'b0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: tap=%h valid=%b idx=%0d, required no tap",
                             tap, tap_valid, tap_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (tap !== e[10:3] || tap_valid !== 1'b1 || tap_idx !== e[2:0]) begin
                        n_fail++;
                        $display("FAIL sb_tap: tap=%h valid=%b idx=%0d, required tap=%h valid=1 idx=%0d",
                                 tap, tap_valid, tap_idx, e[10:3], e[2:0]);
                    end
                end
            end else begin
                n_checks++;
                if (tap_idx !== 3'd0) begin
                    n_fail++;
                    $display("FAIL sb_idle_idx: tap_idx=%0d, required 0", tap_idx);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        pause = 1'b0;
        sw    = 8'h00;
        #12;
        n_checks++;
        if (tap !== 8'h00 || tap_valid !== 1'b0 || tap_idx !== 3'd0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: tap=%h valid=%b idx=%0d pending=%h, required all 0",
                     tap, tap_valid, tap_idx, pending);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_single_press();
        sw = 8'h04;
        exp_q.push_back(mk(8'h04));
        tick(Lat - 1);
        n_checks++;
        if (tap !== 8'h00) begin
            n_fail++;
            $display("FAIL single_early: tap=%h at edge %0d, required 00", tap, Lat - 1);
        end
        tick(1);
        n_checks++;
        if (tap !== 8'h04 || tap_idx !== 3'd2 || tap_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: tap=%h idx=%0d valid=%b, required 04 2 1",
                     tap, tap_idx, tap_valid);
        end
        for (int k = 0; k < 6; k++) begin
            tick(1);
            n_checks++;
            if (tap !== 8'h00) begin
                n_fail++;
                $display("FAIL single_held: tap=%h while held, required 00", tap);
            end
        end
        sw = 8'h00;
        tick(Lat + 2);
    endtask

    task automatic test_glitch();
        sw = 8'h20;
        tick(3);
        sw = 8'h00;
        for (int k = 0; k < Lat + 4; k++) begin
            tick(1);
            n_checks++;
            if (pending !== 8'h00) begin
                n_fail++;
                $display("FAIL glitch_pending: pending=%h, required 00", pending);
            end
        end
    endtask

    task automatic test_simultaneous();
        sw = 8'h81;
        exp_q.push_back(mk(8'h01));
        exp_q.push_back(mk(8'h80));
        tick(Lat);
        n_checks++;
        if (tap !== 8'h01) begin
            n_fail++;
            $display("FAIL simul_first: tap=%h, required 01", tap);
        end
        tick(1);
        n_checks++;
        if (tap !== 8'h80 || tap_idx !== 3'd7 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL simul_second: tap=%h idx=%0d pending=%h, required 80 7 00",
                     tap, tap_idx, pending);
        end
        tick(1);
        n_checks++;
        if (tap !== 8'h00) begin
            n_fail++;
            $display("FAIL simul_after: tap=%h, required 00", tap);
        end
        sw = 8'h00;
        tick(Lat + 2);
    endtask

    task automatic test_pause_press();
        pause = 1'b1;
        sw    = 8'h08;
        tick(Lat + 4);
        pause = 1'b0;
        tick(Lat + 4);
        n_checks++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL pause_held: pending=%h after unpause, required 00", pending);
        end
        sw = 8'h00;
        tick(Lat + 2);
        sw = 8'h08;
        exp_q.push_back(mk(8'h08));
        tick(Lat);
        n_checks++;
        if (tap !== 8'h08 || tap_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL pause_repress: tap=%h idx=%0d, required 08 3", tap, tap_idx);
        end
        sw = 8'h00;
        tick(Lat + 2);
    endtask

    task automatic test_pause_flush();
        sw = 8'h0E;
        exp_q.push_back(mk(8'h02));
        tick(Lat);
        n_checks++;
        if (tap !== 8'h02 || pending !== 8'h0C) begin
            n_fail++;
            $display("FAIL flush_first: tap=%h pending=%h, required 02 0c", tap, pending);
        end
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            n_checks++;
            if (tap !== 8'h00 || pending !== 8'h00) begin
                n_fail++;
                $display("FAIL flush_paused: tap=%h pending=%h, required 00 00", tap, pending);
            end
        end
        pause = 1'b0;
        tick(Lat);
        sw = 8'h00;
        tick(Lat + 2);
    endtask

    task automatic test_async_reset();
        sw = 8'hFF;
        exp_q.push_back(mk(8'h01));
        exp_q.push_back(mk(8'h02));
        tick(Lat + 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tap !== 8'h00 || tap_valid !== 1'b0 || tap_idx !== 3'd0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: tap=%h valid=%b idx=%0d pending=%h, required all 0",
                     tap, tap_valid, tap_idx, pending);
        end
        sw = 8'h00;
        tick(3);
        rst_n = 1'b1;
        tick(Lat + 6);
        n_checks++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL async_after: pending=%h, required 00", pending);
        end
    endtask

    task automatic test_power_up();
        rst_n = 1'b0;
        sw    = 8'h10;
        tick(2);
        rst_n = 1'b1;
        exp_q.push_back(mk(8'h10));
        tick(Lat);
        n_checks++;
        if (tap !== 8'h10 || tap_idx !== 3'd4) begin
            n_fail++;
            $display("FAIL power_up: tap=%h idx=%0d, required 10 4", tap, tap_idx);
        end
        tick(Lat);
        sw = 8'h00;
        tick(Lat + 2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_pause_press();
        test_pause_flush();
        test_async_reset();
        test_power_up();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected taps never seen, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
